// File: rtl/uart_tx_mmio.sv
// uart_tx_fifo: generic circular-buffer FIFO used as the UART transmit queue.
// Latency: a write is visible at rd_dat on the cycle after the push edge; rd_dat shows the head combinationally.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: clk/rst_n clock and async active-low reset; wr_vld/wr_dat push; rd_rdy pop; rd_dat head;
//        full/empty flags; count holds 0..DEPTH entries.
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
      if (rd_rdy) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_vld, rd_rdy})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

endmodule

// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO on the CPU bus.
// Latency: bus ack one cycle after request; first start bit begins on the edge after the ack cycle.
// Backpressure: TXDATA writes stall (mem_ready_o low) while the FIFO is full; all else acks at once.
// Ports: clk_i/rst_i clock and async active-low reset; read_i/write_i/addr_i/data_i bus request;
//        mem_ready_o one-cycle ack with registered data_o; tx_o registered serial line, idle high.
module uart_tx_mmio #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        mem_ready_o,
  output logic [31:0] data_o,
  output logic        tx_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_BAUD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [7:0]       fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic [3:0]       cnt_sat;

  logic [15:0] baud_div;

  state_t      state, state_nx;
  logic [7:0]  shift, shift_nx;
  logic [2:0]  bit_idx, bit_nx;
  logic [15:0] timer, timer_nx;
  logic [15:0] div_lat, div_nx;
  logic        tx_nx;

  logic        req;
  logic        acc;
  logic        busy;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^data_i[31:16];

  // ---------------------------------------------------------------- bus
  // A request is only taken while the ack is low, so a held request sees a
  // mandatory gap cycle and is never accepted twice.
  assign req       = (read_i | write_i) & ~mem_ready_o;
  assign acc       = req & ~(write_i & (addr_i == A_TXDATA) & fifo_full);
  assign fifo_push = acc & write_i & (addr_i == A_TXDATA);
  assign busy      = (state != S_IDLE);

  generate
    if (CNT_W > 4) begin : g_sat
      assign cnt_sat = (fifo_cnt > CNT_W'(15)) ? 4'hF : fifo_cnt[3:0];
    end else begin : g_nosat
      assign cnt_sat = 4'(fifo_cnt);
    end
  endgenerate

  always_comb begin
    rd_val = 32'h0;
    case (addr_i)
      A_STATUS: rd_val = {24'h0, cnt_sat, 1'b0, fifo_empty, fifo_full, busy};
      A_BAUD:   rd_val = {16'h0, baud_div};
      default:  rd_val = 32'h0;
    endcase
  end

  // Write wins when read and write are both asserted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_ready_o <= 1'b0;
      data_o      <= 32'h0;
      baud_div    <= 16'(DEFAULT_DIV);
    end else begin
      mem_ready_o <= acc;
      data_o      <= (acc & ~write_i) ? rd_val : 32'h0;
      if (acc & write_i & (addr_i == A_BAUD)) begin
        // A zero divisor would stall the bit timer, so clamp to one.
        baud_div <= (data_i[15:0] == 16'h0) ? 16'd1 : data_i[15:0];
      end
    end
  end

  // ---------------------------------------------------------------- fifo
  uart_tx_fifo #(
    .DW    (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .wr_vld (fifo_push),
    .wr_dat (data_i[7:0]),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  // ---------------------------------------------------------------- fsm
  // The divisor is latched at each pop so a mid-frame BAUD_DIV write only
  // affects the following frame. tx_o is derived from the next state so it
  // changes on the same edge as the state.
  always_comb begin
    state_nx = state;
    shift_nx = shift;
    bit_nx   = bit_idx;
    timer_nx = timer;
    div_nx   = div_lat;
    fifo_pop = 1'b0;
    tx_nx    = 1'b1;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_nx = fifo_head;
          div_nx   = baud_div;
          timer_nx = baud_div - 16'd1;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (timer == 16'd0) begin
          state_nx = S_DATA;
          bit_nx   = 3'd0;
          timer_nx = div_lat - 16'd1;
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      S_DATA: begin
        if (timer == 16'd0) begin
          timer_nx = div_lat - 16'd1;
          if (bit_idx == 3'd7) begin
            state_nx = S_STOP;
          end else begin
            bit_nx   = bit_idx + 3'd1;
            shift_nx = {1'b0, shift[7:1]};
          end
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      S_STOP: begin
        if (timer == 16'd0) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle cycle between stop and start.
            fifo_pop = 1'b1;
            shift_nx = fifo_head;
            div_nx   = baud_div;
            timer_nx = baud_div - 16'd1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      shift   <= 8'h0;
      bit_idx <= 3'd0;
      timer   <= 16'd0;
      div_lat <= 16'd1;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_idx <= bit_nx;
      timer   <= timer_nx;
      div_lat <= div_nx;
      tx_o    <= tx_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_i;
  logic        write_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic        mem_ready_o;
  logic [31:0] data_o;
  logic        tx_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx_mmio #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (434)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .read_i      (read_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .mem_ready_o (mem_ready_o),
    .data_o      (data_o),
    .tx_o        (tx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stall);
    @(negedge clk);
    write_i = wr;
    read_i  = ~wr;
    addr_i  = a;
    data_i  = d;
    stall   = 0;
    @(negedge clk);
    while (!mem_ready_o && stall < 500) begin
      stall++;
      @(negedge clk);
    end
    if (!mem_ready_o) check_eq("bus_timeout", 32'(mem_ready_o), 32'd1);
    rd      = data_o;
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, output int stall);
    logic [31:0] dummy;
    bus_op(1'b1, a, d, dummy, stall);
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] r);
    int s;
    bus_op(1'b0, a, 32'h0, r, s);
  endtask

  // Waits for tx_o to go low, then returns the length of the low run in cycles.
  task automatic measure_low(output int n, output int t);
    int k;
    n = 0;
    k = 0;
    @(negedge clk);
    while (tx_o !== 1'b0 && k < 300) begin
      k++;
      @(negedge clk);
    end
    t = cyc;
    while (tx_o === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Serial receiver: samples the first cycle of every bit at mon_div cycles/bit.
  logic       mon_en  = 1'b0;
  int         mon_div = 2;
  logic [7:0] rx_byte[$];
  logic       rx_stop[$];
  int         rx_t[$];

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx_o === 1'b0) begin
        automatic int         d  = mon_div;
        automatic int         t0 = cyc;
        automatic logic [7:0] b  = 8'h0;
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (d) @(negedge clk);
        rx_stop.push_back(tx_o);
        rx_byte.push_back(b);
        rx_t.push_back(t0);
        repeat (d - 1) @(negedge clk);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  logic [31:0] r2;
  int          s;
  logic        lv[40];
  logic [9:0]  exp55;
  int          n1, n2, t1, t2;
  int          lows;
  logic [3:0]  pat;
  logic [3:0]  exp_pat;

  initial begin
    rst_n   = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    addr_i  = 2'd0;
    data_i  = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(mem_ready_o), 32'd0);
    check_eq("rst_data",  data_o,           32'h0);
    check_eq("rst_tx",    32'(tx_o),        32'd1);
    rst_n = 1'b1;

    reg_rd(2'd1, r);
    check_eq("status_reset", r, 32'h4);
    reg_rd(2'd2, r);
    check_eq("baud_reset", r, 32'd434);
    check_eq("tx_idle", 32'(tx_o), 32'd1);

    // 0x55 frame at 4 cycles/bit: start, bits LSB first, stop.
    reg_wr(2'd2, 32'd4, s);
    reg_wr(2'd0, 32'h55, s);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          lv[i] = tx_o;
        end
      end
      begin
        repeat (9) @(negedge clk);
        reg_rd(2'd1, r2);
      end
    join
    exp55 = 10'b10_1010_1010;
    for (int i = 0; i < 40; i++)
      check_eq($sformatf("frame55[%0d]", i), 32'(lv[i]), 32'(exp55[i / 4]));
    check_eq("status_busy", r2, 32'h5);
    @(negedge clk);
    check_eq("idle_after55", 32'(tx_o), 32'd1);
    reg_rd(2'd1, r);
    check_eq("status_after55", r, 32'h4);

    // Burst at 2 cycles/bit: nine writes fill shift register + FIFO, tenth stalls.
    reg_wr(2'd2, 32'd2, s);
    rx_byte.delete();
    rx_stop.delete();
    rx_t.delete();
    mon_div = 2;
    mon_en  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      reg_wr(2'd0, 32'(i), s);
      check_eq($sformatf("burst_stall%0d", i), 32'(s), 32'd0);
    end
    reg_rd(2'd1, r);
    check_eq("status_full", r, 32'h83);
    reg_wr(2'd0, 32'd10, s);
    check_eq("stall_cycles", 32'(s), 32'd2);
    for (int k = 0; k < 400 && rx_byte.size() < 10; k++) @(negedge clk);
    check_eq("burst_count", 32'(rx_byte.size()), 32'd10);
    for (int i = 0; i < rx_byte.size(); i++) begin
      check_eq($sformatf("burst_byte%0d", i), 32'(rx_byte[i]), 32'(i + 1));
      check_eq($sformatf("burst_stop%0d", i), 32'(rx_stop[i]), 32'd1);
      if (i > 0)
        check_eq($sformatf("burst_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'd20);
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    // Divisor zero clamps to one.
    reg_wr(2'd2, 32'd0, s);
    reg_rd(2'd2, r);
    check_eq("baud_zero", r, 32'd1);

    // Mid-frame divisor change applies to the next frame only.
    reg_wr(2'd2, 32'd4, s);
    fork
      begin
        measure_low(n1, t1);
        measure_low(n2, t2);
      end
      begin
        reg_wr(2'd0, 32'hFF, s);
        reg_wr(2'd0, 32'hFF, s);
        repeat (6) @(negedge clk);
        reg_wr(2'd2, 32'd8, s);
      end
    join
    check_eq("start_len_div4", 32'(n1), 32'd4);
    check_eq("start_len_div8", 32'(n2), 32'd8);
    check_eq("frame_len_div4", 32'(t2 - t1), 32'd40);
    repeat (80) @(negedge clk);
    reg_rd(2'd2, r);
    check_eq("baud_readback8", r, 32'd8);

    // Reset in the middle of a data bit with three bytes queued.
    reg_wr(2'd2, 32'd4, s);
    for (int i = 0; i < 4; i++) reg_wr(2'd0, 32'h00, s);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_tx_low", 32'(tx_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_tx_async", 32'(tx_o), 32'd1);
    check_eq("reset_ready", 32'(mem_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reg_rd(2'd1, r);
    check_eq("status_post_reset", r, 32'h4);
    reg_rd(2'd2, r);
    check_eq("baud_post_reset", r, 32'd434);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    check_eq("no_frames_after_reset", 32'(lows), 32'd0);

    // Reserved and TXDATA reads return zero.
    reg_rd(2'd3, r);
    check_eq("read_rsvd", r, 32'h0);
    reg_rd(2'd0, r);
    check_eq("read_txdata", r, 32'h0);

    // Held read: ack must alternate, never back to back.
    @(negedge clk);
    read_i = 1'b1;
    addr_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = mem_ready_o;
    end
    read_i = 1'b0;
    exp_pat = 4'b0101;
    check_eq("held_read_ack", 32'(pat), 32'(exp_pat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
